time_display_mux: RTL and testbench
===================================

// Module: time_display_mux
// PURPOSE
//  Consumes hour/tenmin/min from the time counter and drives a 4-digit
//  multiplexed 7-segment display as H H : M M in 12-hour form.
//  Scans one digit at a time, snapshots inputs once per frame (no tearing),
//  blinks the colon at 1 Hz and shows a dash for out-of-range digits.
// PARAMETERS
//  SYS_FREQ     100000000  clk frequency in Hz
//  REFRESH_HZ   1000       per-digit dwell rate; DIV = SYS_FREQ/REFRESH_HZ cycles per digit
//  COMMON_ANODE 1          1: an/seg/dp active-low; 0: active-high
// PORTS
//  clk     in   1  system clock
//  rst     in   1  synchronous, active-high reset
//  hour    in   4  0..11 (0 displays as 12)
//  tenmin  in   4  0..5
//  min     in   4  0..9
//  blank   in   1  1 = all digits off; counters keep running
//  an      out  4  digit enables; an[3]=hour tens ... an[0]=min
//  seg     out  7  segments, seg[0]=a ... seg[6]=g
//  dp      out  1  decimal point; used as colon on digit 2
// BEHAVIOUR
//  Reset and polarity
//  - Reset: an, seg and dp all inactive. With COMMON_ANODE=1: an=4'hF, seg=7'h7F, dp=1.
//  - Reset also clears: div_cnt=0, idx=0, colon counter=0, colon=1, shadow regs=0.
//  - All polarity inversion is applied at the output registers only.
//  Scan timing
//  - div_cnt counts 0..DIV-1 and wraps; tick = (div_cnt==DIV-1).
//  - On tick, idx advances 3->2->1->0->3 (wraps 0->3).
//  - Snapshot: on tick with idx==0, latch hour/tenmin/min into shadow regs.
//    The new frame starting at idx=3 uses the new values.
//  - Mid-frame input changes have no visible effect until the next frame.
//  Digit decode (from shadow regs)
//  - H = (hour==0) ? 12 : hour.
//  - digit3 = '1' if H>=10, else blank (anode off). digit2 = H mod 10.
//  - digit1 = tenmin; digit0 = min.
//  - hour>11: digits 3 and 2 show dash. tenmin>5: digit1 dash. min>9: digit0 dash.
//  - Active-high gfedcba codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F dash=40.
//  Colon
//  - Colon counter wraps at SYS_FREQ/2-1; colon toggles on each wrap.
//  - dp is active only while idx==2, colon==1 and blank==0.
//  Output timing
//  - an/seg/dp are registered: they reflect idx/shadow one cycle after a change.
//  - Exactly one anode is active at a time (none for a blank digit3 or when blank=1).
//  - blank=1 forces an inactive on the next cycle; display resumes the cycle after
//    blank=0 at the current idx.
//  - Reset asserted mid-frame returns everything to reset values on the next edge.
// TESTING  (SYS_FREQ=1000, REFRESH_HZ=100 -> DIV=10)
//  1. Reset 3 cycles -> an=F seg=7F dp=1; first tick at cycle 10 after release;
//     idx then cycles 3,2,1,0 every 10 cycles.
//  2. hour=0 tenmin=0 min=0, after one frame -> digits 3..0 seg active-high
//     06,5B,3F,3F ("12:00"); dp active on digit2 only.
//  3. hour=9 tenmin=4 min=7 -> digit3 anode never active; digits 2,1,0 = 6F,66,07.
//  4. Change min 3->8 while idx==2 -> digit0 still shows 4F this frame, 7F from next frame.
//  5. min=12, hour=14 -> digit0 and digits 3,2 = 40; tenmin digit decodes normally.
//  6. Colon toggles every 500 cycles (dp on digit2 on/off); blank=1 -> an=F next cycle,
//     and idx progression continues unchanged.

Source files
------------

// File: rtl/time_display_mux.sv
// time_display_mux
// Drives a 4-digit multiplexed 7-segment display as "HH:MM" in 12-hour
// form. One digit is lit at a time. The inputs are sampled once per frame,
// so a frame never shows a mix of old and new values. The colon blinks at
// 1 Hz, and any digit that is out of range shows a dash.
// Digit order: an[3] is hour tens, an[2] is hour units (its dp is the
// colon), an[1] is ten-minutes and an[0] is minutes.

module time_display_mux #(
    parameter int SYS_FREQ     = 100000000,
    parameter int REFRESH_HZ   = 1000,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hour,
    input  logic [3:0] tenmin,
    input  logic [3:0] min,
    input  logic       blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int DIV        = SYS_FREQ / REFRESH_HZ;
    localparam int DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int COLON_MAX  = SYS_FREQ / 2 - 1;
    localparam int COLON_W    = (COLON_MAX > 0) ? $clog2(COLON_MAX + 1) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [COLON_W-1:0] COLON_LAST = COLON_W'(COLON_MAX);

    // Idle levels of the pins. These depend on the display wiring.
    localparam logic [3:0] AN_OFF  = COMMON_ANODE ? 4'hF  : 4'h0;
    localparam logic [6:0] SEG_OFF = COMMON_ANODE ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = COMMON_ANODE ? 1'b1  : 1'b0;

    localparam logic [3:0] DIGIT_DASH = 4'hF;

    // Segment pattern for one digit, active-high, in gfedcba order.
    // Any value above 9 shows a dash.
    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] c;
        c = 7'h40;
        case (v)
            4'd0:    c = 7'h3F;
            4'd1:    c = 7'h06;
            4'd2:    c = 7'h5B;
            4'd3:    c = 7'h4F;
            4'd4:    c = 7'h66;
            4'd5:    c = 7'h6D;
            4'd6:    c = 7'h7D;
            4'd7:    c = 7'h07;
            4'd8:    c = 7'h7F;
            4'd9:    c = 7'h6F;
            default: c = 7'h40;
        endcase
        return c;
    endfunction

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [COLON_W-1:0] colon_cnt_q, colon_cnt_d;
    logic               colon_q, colon_d;
    logic [3:0]         hour_sh_q, hour_sh_d;
    logic [3:0]         tenmin_sh_q, tenmin_sh_d;
    logic [3:0]         min_sh_q, min_sh_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic               tick;
    logic               colon_wrap;
    logic [3:0]         h_disp;
    logic               hour_bad;
    logic [3:0]         digit_val;
    logic               digit_on;
    logic [3:0]         an_act;
    logic [6:0]         seg_act;
    logic               dp_act;

    // Digit dwell timer. It also moves the scan index: 3, 2, 1, 0, then back to 3.
    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        idx_d     = tick ? idx_q - 2'd1 : idx_q;
    end

    // Take a snapshot of the time on the last tick of a frame. The next
    // frame, which starts at digit 3, shows these values.
    always_comb begin
        hour_sh_d   = hour_sh_q;
        tenmin_sh_d = tenmin_sh_q;
        min_sh_d    = min_sh_q;
        if (tick && (idx_q == 2'd0)) begin
            hour_sh_d   = hour;
            tenmin_sh_d = tenmin;
            min_sh_d    = min;
        end
    end

    // Half-second timebase that flips the colon.
    always_comb begin
        colon_wrap  = (colon_cnt_q == COLON_LAST);
        colon_cnt_d = colon_wrap ? '0 : colon_cnt_q + 1'b1;
        colon_d     = colon_wrap ? ~colon_q : colon_q;
    end

    // Work out the digit for the current scan position from the snapshot.
    always_comb begin
        h_disp    = (hour_sh_q == 4'd0) ? 4'd12 : hour_sh_q;
        hour_bad  = (hour_sh_q > 4'd11);
        digit_val = 4'd0;
        digit_on  = 1'b1;
        case (idx_q)
            2'd3: begin
                if (hour_bad) begin
                    digit_val = DIGIT_DASH;
                end else if (h_disp >= 4'd10) begin
                    digit_val = 4'd1;
                end else begin
                    digit_on  = 1'b0;
                end
            end
            2'd2: begin
                if (hour_bad) begin
                    digit_val = DIGIT_DASH;
                end else if (h_disp >= 4'd10) begin
                    digit_val = h_disp - 4'd10;
                end else begin
                    digit_val = h_disp;
                end
            end
            2'd1:    digit_val = (tenmin_sh_q > 4'd5) ? DIGIT_DASH : tenmin_sh_q;
            default: digit_val = (min_sh_q > 4'd9) ? DIGIT_DASH : min_sh_q;
        endcase
    end

    // Pin drive in logical (active-high) form. Polarity is flipped only when
    // the value is loaded into the output registers.
    always_comb begin
        an_act  = 4'h0;
        seg_act = 7'h00;
        dp_act  = 1'b0;
        if (!blank) begin
            if (digit_on) begin
                an_act  = 4'b0001 << idx_q;
                seg_act = seg_code(digit_val);
            end
            dp_act = (idx_q == 2'd2) && colon_q;
        end
        an_d  = COMMON_ANODE ? ~an_act  : an_act;
        seg_d = COMMON_ANODE ? ~seg_act : seg_act;
        dp_d  = COMMON_ANODE ? ~dp_act  : dp_act;
    end

    // All state registers, with a synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q   <= '0;
            idx_q       <= 2'd0;
            colon_cnt_q <= '0;
            colon_q     <= 1'b1;
            hour_sh_q   <= 4'd0;
            tenmin_sh_q <= 4'd0;
            min_sh_q    <= 4'd0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= DP_OFF;
        end else begin
            div_cnt_q   <= div_cnt_d;
            idx_q       <= idx_d;
            colon_cnt_q <= colon_cnt_d;
            colon_q     <= colon_d;
            hour_sh_q   <= hour_sh_d;
            tenmin_sh_q <= tenmin_sh_d;
            min_sh_q    <= min_sh_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_time_display_mux.sv
// Testbench for time_display_mux. SYS_FREQ=1000 and REFRESH_HZ=100 give
// DIV=10 and a 500-cycle colon half-period.
// cyc counts clock edges since reset was released. After edge c, the
// outputs show scan position (c-11) mod 40: 0..9 is digit3, 10..19 is
// digit2, 20..29 is digit1 and 30..39 is digit0.

module tb_time_display_mux;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] hour, tenmin, min;
    logic       blank;
    logic [3:0] an, an_ah;
    logic [6:0] seg, seg_ah;
    logic       dp, dp_ah;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    time_display_mux #(.SYS_FREQ(1000), .REFRESH_HZ(100), .COMMON_ANODE(1'b1)) u_dut (
        .clk(clk), .rst(rst), .hour(hour), .tenmin(tenmin), .min(min),
        .blank(blank), .an(an), .seg(seg), .dp(dp)
    );

    time_display_mux #(.SYS_FREQ(1000), .REFRESH_HZ(100), .COMMON_ANODE(1'b0)) u_dut_ah (
        .clk(clk), .rst(rst), .hour(hour), .tenmin(tenmin), .min(min),
        .blank(blank), .an(an_ah), .seg(seg_ah), .dp(dp_ah)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    function automatic int phase();
        return ((cyc - 11) % 40 + 40) % 40;
    endfunction

    function automatic bit colon_exp();
        return (((cyc - 1) / 500) % 2) == 0;
    endfunction

    task automatic step_to_phase(input int p);
        do step(1); while (phase() != p);
    endtask

    task automatic next_frame();
        step_to_phase(39);
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; blank = 1'b0; hour = 4'd0; tenmin = 4'd0; min = 4'd0;
        step(3);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_ca: got an=%h seg=%h dp=%b, want an=F seg=7F dp=1", an, seg, dp);
        end
        checks++;
        if (an_ah !== 4'h0 || seg_ah !== 7'h00 || dp_ah !== 1'b0) begin
            errors++;
            $display("FAIL reset_ah: got an=%h seg=%h dp=%b, want an=0 seg=00 dp=0", an_ah, seg_ah, dp_ah);
        end
        rst = 1'b0;
        cyc = 0;
        step(9);
        checks++;
        if (an !== 4'hE || seg !== ~7'h3F) begin
            errors++;
            $display("FAIL idx0_after_reset: got an=%h seg=%h, want an=E seg=%h", an, seg, ~7'h3F);
        end
        step(1);
        checks++;
        if (an !== 4'hE) begin
            errors++;
            $display("FAIL pre_first_tick: got an=%h, want E at cycle 10", an);
        end
        step(1);
        checks++;
        if (an !== 4'h7 || seg !== ~7'h06) begin
            errors++;
            $display("FAIL first_tick_digit3: got an=%h seg=%h, want an=7 seg=%h", an, seg, ~7'h06);
        end
        step(9);
        checks++;
        if (an !== 4'h7) begin
            errors++;
            $display("FAIL digit3_dwell_end: got an=%h, want 7 at cycle 20", an);
        end
        step(1);
        checks++;
        if (an !== 4'hB) begin
            errors++;
            $display("FAIL idx2_at_21: got an=%h, want B", an);
        end
        step(10);
        checks++;
        if (an !== 4'hD) begin
            errors++;
            $display("FAIL idx1_at_31: got an=%h, want D", an);
        end
        step(10);
        checks++;
        if (an !== 4'hE) begin
            errors++;
            $display("FAIL idx0_at_41: got an=%h, want E", an);
        end
        step(10);
        checks++;
        if (an !== 4'h7) begin
            errors++;
            $display("FAIL idx3_wrap_at_51: got an=%h, want 7", an);
        end
    endtask

    typedef struct {
        string      name;
        logic [3:0] h, t, m;
        bit         on3;
        logic [6:0] s3, s2, s1, s0;
    } dec_vec_t;

    task automatic test_decode();
        dec_vec_t   v [7];
        logic [6:0] es;
        bit         on;
        logic [3:0] ea;
        v[0] = '{"noon",   4'd0,  4'd0, 4'd0,  1'b1, 7'h06, 7'h5B, 7'h3F, 7'h3F};
        v[1] = '{"nine",   4'd9,  4'd4, 4'd7,  1'b0, 7'h00, 7'h6F, 7'h66, 7'h07};
        v[2] = '{"ten",    4'd10, 4'd5, 4'd9,  1'b1, 7'h06, 7'h3F, 7'h6D, 7'h6F};
        v[3] = '{"eleven", 4'd11, 4'd5, 4'd9,  1'b1, 7'h06, 7'h06, 7'h6D, 7'h6F};
        v[4] = '{"h12_t6", 4'd12, 4'd6, 4'd10, 1'b1, 7'h40, 7'h40, 7'h40, 7'h40};
        v[5] = '{"dash",   4'd14, 4'd3, 4'd12, 1'b1, 7'h40, 7'h40, 7'h4F, 7'h40};
        v[6] = '{"one",    4'd1,  4'd2, 4'd3,  1'b0, 7'h00, 7'h06, 7'h5B, 7'h4F};
        for (int i = 0; i < 7; i++) begin
            hour = v[i].h; tenmin = v[i].t; min = v[i].m;
            next_frame();
            for (int d = 3; d >= 0; d--) begin
                step_to_phase(5 + 10 * (3 - d));
                case (d)
                    3:       es = v[i].s3;
                    2:       es = v[i].s2;
                    1:       es = v[i].s1;
                    default: es = v[i].s0;
                endcase
                on = (d == 3) ? v[i].on3 : 1'b1;
                ea = on ? (4'b0001 << d) : 4'h0;
                checks++;
                if (an !== ~ea || seg !== ~es) begin
                    errors++;
                    $display("FAIL %s_d%0d: got an=%h seg=%h, want an=%h seg=%h",
                             v[i].name, d, an, seg, ~ea, ~es);
                end
                checks++;
                if (an_ah !== ea || seg_ah !== es) begin
                    errors++;
                    $display("FAIL %s_d%0d_ah: got an=%h seg=%h, want an=%h seg=%h",
                             v[i].name, d, an_ah, seg_ah, ea, es);
                end
                checks++;
                if (dp !== ((d == 2 && colon_exp()) ? 1'b0 : 1'b1)) begin
                    errors++;
                    $display("FAIL %s_d%0d_dp: got dp=%b, want %b", v[i].name, d, dp,
                             (d == 2 && colon_exp()) ? 1'b0 : 1'b1);
                end
            end
        end
    endtask

    task automatic test_mid_frame();
        hour = 4'd9; tenmin = 4'd4; min = 4'd3;
        next_frame();
        step_to_phase(15);
        min = 4'd8;
        step_to_phase(35);
        checks++;
        if (an !== 4'hE || seg !== ~7'h4F) begin
            errors++;
            $display("FAIL mid_frame_old: got an=%h seg=%h, want an=E seg=%h", an, seg, ~7'h4F);
        end
        step_to_phase(35);
        checks++;
        if (an !== 4'hE || seg !== ~7'h7F) begin
            errors++;
            $display("FAIL mid_frame_new: got an=%h seg=%h, want an=E seg=%h", an, seg, ~7'h7F);
        end
    endtask

    task automatic test_colon();
        logic exp_dp;
        hour = 4'd0; tenmin = 4'd0; min = 4'd0;
        next_frame();
        while (cyc < 1060) begin
            step(1);
            exp_dp = (phase() >= 10 && phase() <= 19 && colon_exp()) ? 1'b0 : 1'b1;
            checks++;
            if (dp !== exp_dp) begin
                errors++;
                $display("FAIL colon_c%0d: got dp=%b, want %b", cyc, dp, exp_dp);
            end
        end
    endtask

    task automatic test_blank();
        hour = 4'd0; tenmin = 4'd1; min = 4'd2;
        next_frame();
        step_to_phase(12);
        checks++;
        if (an !== 4'hB || seg !== ~7'h5B) begin
            errors++;
            $display("FAIL pre_blank: got an=%h seg=%h, want an=B seg=%h", an, seg, ~7'h5B);
        end
        blank = 1'b1;
        step(1);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || an_ah !== 4'h0) begin
            errors++;
            $display("FAIL blank_next: got an=%h seg=%h dp=%b an_ah=%h, want F 7F 1 0",
                     an, seg, dp, an_ah);
        end
        step_to_phase(25);
        checks++;
        if (an !== 4'hF) begin
            errors++;
            $display("FAIL blank_hold: got an=%h, want F", an);
        end
        blank = 1'b0;
        step(1);
        checks++;
        if (an !== 4'hD || seg !== ~7'h06) begin
            errors++;
            $display("FAIL unblank_idx1: got an=%h seg=%h, want an=D seg=%h", an, seg, ~7'h06);
        end
        step_to_phase(35);
        checks++;
        if (an !== 4'hE || seg !== ~7'h5B) begin
            errors++;
            $display("FAIL unblank_idx0: got an=%h seg=%h, want an=E seg=%h", an, seg, ~7'h5B);
        end
    endtask

    task automatic test_reset_mid();
        hour = 4'd0; tenmin = 4'd3; min = 4'd5;
        while (colon_exp()) step(1);
        step(3);
        rst = 1'b1;
        step(1);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got an=%h seg=%h dp=%b, want an=F seg=7F dp=1", an, seg, dp);
        end
        step(2);
        rst = 1'b0;
        cyc = 0;
        step(5);
        checks++;
        if (an !== 4'hE || seg !== ~7'h3F) begin
            errors++;
            $display("FAIL shadow_cleared: got an=%h seg=%h, want an=E seg=%h", an, seg, ~7'h3F);
        end
        step(6);
        checks++;
        if (an !== 4'h7 || seg !== ~7'h06) begin
            errors++;
            $display("FAIL reset_mid_retick: got an=%h seg=%h, want an=7 seg=%h", an, seg, ~7'h06);
        end
        step(10);
        checks++;
        if (an !== 4'hB || dp !== 1'b0) begin
            errors++;
            $display("FAIL colon_reset_on: got an=%h dp=%b, want an=B dp=0", an, dp);
        end
        step(10);
        checks++;
        if (an !== 4'hD || seg !== ~7'h4F) begin
            errors++;
            $display("FAIL reset_mid_tenmin: got an=%h seg=%h, want an=D seg=%h", an, seg, ~7'h4F);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mid_frame();
        test_colon();
        test_blank();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
